// File: rtl/sump3_lb_bridge_pkg.sv
// Shared definitions for the byte-stream to SUMP3 local-bus bridge:
// opcode values, opcode byte field positions and FSM state encoding.
package sump3_lb_bridge_pkg;

   localparam logic [1:0] OP_WR_CTRL = 2'd0;
   localparam logic [1:0] OP_WR_DATA = 2'd1;
   localparam logic [1:0] OP_RD_CTRL = 2'd2;
   localparam logic [1:0] OP_RD_DATA = 2'd3;

   localparam int unsigned OP_SEL_LO = 0;
   localparam int unsigned OP_SEL_HI = 1;
   localparam int unsigned OP_RSV_LO = 2;
   localparam int unsigned OP_RSV_HI = 3;
   localparam int unsigned OP_CNT_LO = 4;
   localparam int unsigned OP_CNT_HI = 7;

   typedef enum logic [2:0] {
      StIdle,
      StWrCollect,
      StWrStrobe,
      StRdStrobe,
      StRdWait,
      StRdSend
   } state_e;

   function automatic logic op_is_read(input logic [1:0] op);
      return (op == OP_RD_CTRL) || (op == OP_RD_DATA);
   endfunction

   function automatic logic op_is_data(input logic [1:0] op);
      return (op == OP_WR_DATA) || (op == OP_RD_DATA);
   endfunction

endpackage

// File: rtl/sump3_lb_bridge.sv
// Byte-stream command decoder driving the SUMP3 local bus: burst writes from rx bytes,
// burst reads returned as tx bytes MSB first, with a read timeout that substitutes a marker.
module sump3_lb_bridge
   import sump3_lb_bridge_pkg::*;
#(
   parameter int unsigned rd_timeout   = 1024,
   parameter logic [31:0] timeout_word = 32'hDEADBEEF
) (
   input  logic        clk_lb,
   input  logic        reset_n,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        lb_cs_ctrl,
   output logic        lb_cs_data,
   output logic        lb_wr,
   output logic        lb_rd,
   output logic [31:0] lb_wr_d,
   input  logic [31:0] lb_rd_d,
   input  logic        lb_rd_rdy,
   output logic        err_pulse
);

   localparam logic [15:0] TmoLast = 16'(rd_timeout - 1);

   state_e      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic [1:0]  bcnt_q, bcnt_d;
   logic [31:0] wr_word_q, wr_word_d;
   logic [31:0] rd_word_q, rd_word_d;
   logic [15:0] tmo_q, tmo_d;
   logic        err_q, err_d;
   logic        timeout_hit;

   always_ff @(posedge clk_lb or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         op_q      <= 2'd0;
         wcnt_q    <= 4'd0;
         bcnt_q    <= 2'd0;
         wr_word_q <= 32'd0;
         rd_word_q <= 32'd0;
         tmo_q     <= 16'd0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         wcnt_q    <= wcnt_d;
         bcnt_q    <= bcnt_d;
         wr_word_q <= wr_word_d;
         rd_word_q <= rd_word_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      wcnt_d      = wcnt_q;
      bcnt_d      = bcnt_q;
      wr_word_d   = wr_word_q;
      rd_word_d   = rd_word_q;
      tmo_d       = tmo_q;
      err_d       = 1'b0;
      timeout_hit = 1'b0;
      rx_ready    = 1'b0;
      tx_valid    = 1'b0;
      lb_wr       = 1'b0;
      lb_rd       = 1'b0;

      unique case (state_q)
         StIdle: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               if (rx_byte[OP_RSV_HI:OP_RSV_LO] != 2'b00) begin
                  err_d = 1'b1;
               end else begin
                  op_d    = rx_byte[OP_SEL_HI:OP_SEL_LO];
                  wcnt_d  = rx_byte[OP_CNT_HI:OP_CNT_LO];
                  bcnt_d  = 2'd0;
                  state_d = op_is_read(rx_byte[OP_SEL_HI:OP_SEL_LO]) ? StRdStrobe : StWrCollect;
               end
            end
         end
         StWrCollect: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               wr_word_d = {wr_word_q[23:0], rx_byte};
               bcnt_d    = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  state_d = StWrStrobe;
               end
            end
         end
         StWrStrobe: begin
            lb_wr = 1'b1;
            if (wcnt_q == 4'd0) begin
               state_d = StIdle;
            end else begin
               wcnt_d  = wcnt_q - 4'd1;
               state_d = StWrCollect;
            end
         end
         StRdStrobe: begin
            lb_rd  = 1'b1;
            tmo_d  = 16'd0;
            bcnt_d = 2'd0;
            // A bus that answers in the strobe cycle itself skips the wait state.
            if (lb_rd_rdy) begin
               rd_word_d = lb_rd_d;
               state_d   = StRdSend;
            end else begin
               state_d = StRdWait;
            end
         end
         StRdWait: begin
            if (lb_rd_rdy) begin
               rd_word_d = lb_rd_d;
               state_d   = StRdSend;
            end else if (tmo_q == TmoLast) begin
               rd_word_d   = timeout_word;
               timeout_hit = 1'b1;
               state_d     = StRdSend;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         StRdSend: begin
            tx_valid = 1'b1;
            if (tx_ready) begin
               rd_word_d = {rd_word_q[23:0], 8'h00};
               bcnt_d    = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  if (wcnt_q == 4'd0) begin
                     state_d = StIdle;
                  end else begin
                     wcnt_d  = wcnt_q - 4'd1;
                     state_d = StRdStrobe;
                  end
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign tx_byte    = rd_word_q[31:24];
   assign lb_wr_d    = wr_word_q;
   assign lb_cs_ctrl = (lb_wr | lb_rd) & ~op_is_data(op_q);
   assign lb_cs_data = (lb_wr | lb_rd) & op_is_data(op_q);
   // Bad-opcode errors are registered; the timeout pulse is raised in the expiring cycle.
   assign err_pulse  = err_q | timeout_hit;

endmodule

// File: tb/tb_sump3_lb_bridge.sv
// Self-checking bench for sump3_lb_bridge: directed and randomized command bursts checked
// against a queue-based model of the byte protocol, bus responder and timeout rule.
module tb_sump3_lb_bridge;

   localparam int unsigned RdTimeout   = 16;
   localparam logic [31:0] TimeoutWord = 32'hDEADBEEF;

   logic        clk_lb = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        lb_cs_ctrl, lb_cs_data, lb_wr, lb_rd;
   logic [31:0] lb_wr_d;
   logic [31:0] lb_rd_d = 32'h0;
   logic        lb_rd_rdy = 1'b0;
   logic        err_pulse;

   sump3_lb_bridge #(
      .rd_timeout  (RdTimeout),
      .timeout_word(TimeoutWord)
   ) dut (
      .clk_lb    (clk_lb),
      .reset_n   (reset_n),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .tx_byte   (tx_byte),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .lb_cs_ctrl(lb_cs_ctrl),
      .lb_cs_data(lb_cs_data),
      .lb_wr     (lb_wr),
      .lb_rd     (lb_rd),
      .lb_wr_d   (lb_wr_d),
      .lb_rd_d   (lb_rd_d),
      .lb_rd_rdy (lb_rd_rdy),
      .err_pulse (err_pulse)
   );

   always #5 clk_lb = ~clk_lb;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   initial forever begin
      @(posedge clk_lb);
      cyc++;
   end

   // Observed traffic, sampled at the falling edge.
   logic [33:0] wr_seen[$];
   int          wr_cyc[$];
   logic [7:0]  tx_seen[$];
   int          rd_cyc[$];
   int          txv_cyc[$];
   int          err_cyc[$];
   int          viol = 0;

   initial begin
      logic       prev_txv, prev_txr;
      logic [7:0] prev_txb;
      prev_txv = 1'b0;
      prev_txr = 1'b0;
      prev_txb = 8'h00;
      forever begin
         @(negedge clk_lb);
         if (reset_n) begin
            if (lb_wr) begin
               wr_seen.push_back({lb_cs_ctrl, lb_cs_data, lb_wr_d});
               wr_cyc.push_back(cyc);
            end
            if (lb_rd) rd_cyc.push_back(cyc);
            if ((lb_wr || lb_rd) && rx_ready) viol++;
            if (lb_wr && lb_rd) viol++;
            if ((lb_wr || lb_rd) && !(lb_cs_ctrl ^ lb_cs_data)) viol++;
            if ((lb_cs_ctrl || lb_cs_data) && !(lb_wr || lb_rd)) viol++;
            if (tx_valid && rx_ready) viol++;
            if (prev_txv && !prev_txr && (!tx_valid || tx_byte !== prev_txb)) viol++;
            if (tx_valid && !prev_txv) txv_cyc.push_back(cyc);
            if (tx_valid && tx_ready) tx_seen.push_back(tx_byte);
            if (err_pulse) err_cyc.push_back(cyc);
         end
         prev_txv = reset_n && tx_valid;
         prev_txr = tx_ready;
         prev_txb = tx_byte;
      end
   end

   // Bus responder: per strobe, a latency in cycles (or -1 for never) and a data word.
   logic [31:0] bus_word_q[$];
   int          bus_lat_q[$];

   initial forever begin
      @(negedge clk_lb);
      if (reset_n && lb_rd && bus_lat_q.size() > 0) begin
         int          lat;
         logic [31:0] w;
         lat = bus_lat_q.pop_front();
         w   = bus_word_q.pop_front();
         if (lat >= 0) begin
            repeat (lat) @(negedge clk_lb);
            lb_rd_rdy = 1'b1;
            lb_rd_d   = w;
            @(negedge clk_lb);
            lb_rd_rdy = 1'b0;
            lb_rd_d   = $urandom();
         end
      end
   end

   bit tx_rand = 1'b0;
   initial forever begin
      @(posedge clk_lb);
      #1;
      tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      wr_seen.delete();
      wr_cyc.delete();
      tx_seen.delete();
      rd_cyc.delete();
      txv_cyc.delete();
      err_cyc.delete();
      viol = 0;
   endtask

   int last_acc = 0;

   // Called at posedge+1; returns at posedge+1 after the byte is taken.
   task automatic send_byte(input logic [7:0] b);
      int gap;
      int budget;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
         rx_valid = 1'b0;
         rx_byte  = 8'($urandom());
         @(posedge clk_lb);
         #1;
      end
      rx_valid = 1'b1;
      rx_byte  = b;
      budget   = 0;
      forever begin
         @(negedge clk_lb);
         if (rx_ready || budget > 300) break;
         budget++;
      end
      if (!rx_ready) chk("rx_accept", 64'(rx_ready), 64'd1);
      last_acc = cyc;
      @(posedge clk_lb);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic wait_done(input int n_tx, input int n_wr);
      int budget;
      budget = 0;
      while ((tx_seen.size() < n_tx || wr_seen.size() < n_wr) && budget < 3000) begin
         @(posedge clk_lb);
         budget++;
      end
      repeat (4) @(posedge clk_lb);
      #1;
   endtask

   logic [31:0] cmd_words[$];
   int          cmd_lats[$];

   task automatic run_cmd(input logic [7:0] opc, input string tag);
      int          n;
      int          acc;
      int          j;
      logic [1:0]  op;
      logic [31:0] w;
      logic [7:0]  exp_tx[$];
      logic [33:0] exp_wr[$];
      int          exp_err;
      n       = int'(opc[7:4]) + 1;
      op      = opc[1:0];
      exp_err = 0;
      clear_obs();
      for (int i = 0; i < n; i++) begin
         if (op[1]) begin
            w = (cmd_lats[i] < 0) ? TimeoutWord : cmd_words[i];
            if (cmd_lats[i] < 0) exp_err++;
            for (int k = 3; k >= 0; k--) exp_tx.push_back(8'(w >> (8 * k)));
            bus_word_q.push_back(cmd_words[i]);
            bus_lat_q.push_back(cmd_lats[i]);
         end else begin
            exp_wr.push_back({op == 2'd0, op == 2'd1, cmd_words[i]});
         end
      end
      send_byte(opc);
      acc = last_acc;
      if (!op[1]) begin
         for (int i = 0; i < n; i++) begin
            for (int k = 3; k >= 0; k--) send_byte(8'(cmd_words[i] >> (8 * k)));
         end
      end
      wait_done(exp_tx.size(), exp_wr.size());
      chk({tag, "_nwr"}, 64'(wr_seen.size()), 64'(exp_wr.size()));
      chk({tag, "_ntx"}, 64'(tx_seen.size()), 64'(exp_tx.size()));
      chk({tag, "_nerr"}, 64'(err_cyc.size()), 64'(exp_err));
      chk({tag, "_viol"}, 64'(viol), 64'd0);
      chk({tag, "_idle_rx_ready"}, 64'(rx_ready), 64'd1);
      if (wr_seen.size() == exp_wr.size()) begin
         foreach (exp_wr[i]) chk($sformatf("%s_wr%0d", tag, i), 64'(wr_seen[i]), 64'(exp_wr[i]));
         if (n > 0 && !op[1]) chk({tag, "_wr_lat"}, 64'(wr_cyc[n-1]), 64'(last_acc + 1));
      end
      if (tx_seen.size() == exp_tx.size()) begin
         foreach (exp_tx[i]) chk($sformatf("%s_tx%0d", tag, i), 64'(tx_seen[i]), 64'(exp_tx[i]));
      end
      if (op[1] && rd_cyc.size() == n && txv_cyc.size() == n && err_cyc.size() == exp_err) begin
         chk({tag, "_rd_lat"}, 64'(rd_cyc[0]), 64'(acc + 1));
         j = 0;
         for (int i = 0; i < n; i++) begin
            if (cmd_lats[i] < 0) begin
               chk($sformatf("%s_tmo%0d", tag, i), 64'(err_cyc[j] - rd_cyc[i]), 64'(RdTimeout));
               j++;
               chk($sformatf("%s_txv%0d", tag, i), 64'(txv_cyc[i] - rd_cyc[i]),
                   64'(RdTimeout + 1));
            end else begin
               chk($sformatf("%s_txv%0d", tag, i), 64'(txv_cyc[i] - rd_cyc[i]),
                   64'(cmd_lats[i] + 1));
            end
         end
      end else if (op[1]) begin
         chk({tag, "_nstrobe"}, 64'(rd_cyc.size()), 64'(n));
      end
   endtask

   initial begin
      int          n;
      logic [1:0]  op;
      logic [7:0]  opc;
      int          budget;

      // Reset values while reset is held.
      #1;
      chk("rst_rx_ready", 64'(rx_ready), 64'd1);
      chk("rst_tx_valid", 64'(tx_valid), 64'd0);
      chk("rst_bus", 64'({lb_cs_ctrl, lb_cs_data, lb_wr, lb_rd}), 64'd0);
      chk("rst_wr_d", 64'(lb_wr_d), 64'd0);
      chk("rst_tx_byte", 64'(tx_byte), 64'd0);
      chk("rst_err", 64'(err_pulse), 64'd0);
      repeat (3) @(posedge clk_lb);
      #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clk_lb);
      #1;

      // Single control write.
      cmd_words = '{32'h00000005};
      run_cmd(8'h00, "wr_ctrl1");

      // Three-word data write burst.
      cmd_words = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
      run_cmd(8'h21, "wr_data3");

      // Two-word data read, bus latency 3, throttled transport.
      tx_rand   = 1'b1;
      cmd_words = '{32'h12345678, 32'hCAFEF00D};
      cmd_lats  = '{3, 3};
      run_cmd(8'h13, "rd_data2");

      // Control read that never answers.
      tx_rand   = 1'b0;
      cmd_words = '{32'h0BADF00D};
      cmd_lats  = '{-1};
      run_cmd(8'h02, "rd_tmo");

      // Reserved bits set: dropped with an error pulse, then a normal read.
      clear_obs();
      send_byte(8'h04);
      repeat (3) @(posedge clk_lb);
      #1;
      chk("badop_nerr", 64'(err_cyc.size()), 64'd1);
      if (err_cyc.size() == 1) chk("badop_err_cyc", 64'(err_cyc[0]), 64'(last_acc + 1));
      chk("badop_nobus", 64'(rd_cyc.size() + wr_seen.size()), 64'd0);
      cmd_words = '{32'hA5A55A5A};
      cmd_lats  = '{2};
      run_cmd(8'h02, "after_bad");

      // Reset in the middle of a read burst.
      clear_obs();
      bus_word_q.push_back(32'h01020304);
      bus_lat_q.push_back(1);
      bus_word_q.push_back(32'h05060708);
      bus_lat_q.push_back(1);
      send_byte(8'h13);
      budget = 0;
      while (tx_seen.size() < 2 && budget < 200) begin
         @(posedge clk_lb);
         budget++;
      end
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_tx_valid", 64'(tx_valid), 64'd0);
      chk("midrst_bus", 64'({lb_cs_ctrl, lb_cs_data, lb_wr, lb_rd}), 64'd0);
      chk("midrst_rx_ready", 64'(rx_ready), 64'd1);
      repeat (3) @(posedge clk_lb);
      #1;
      reset_n = 1'b1;
      bus_word_q.delete();
      bus_lat_q.delete();
      clear_obs();
      repeat (10) @(posedge clk_lb);
      #1;
      chk("midrst_no_more_tx", 64'(tx_seen.size()), 64'd0);
      chk("midrst_no_strobe", 64'(rd_cyc.size()), 64'd0);
      cmd_words = '{32'hFEEDC0DE};
      run_cmd(8'h00, "post_rst_wr");

      // Randomized bursts.
      for (int t = 0; t < 10; t++) begin
         n   = $urandom_range(1, 4);
         op  = 2'($urandom_range(0, 3));
         opc = {4'(n - 1), 2'b00, op};
         tx_rand = 1'($urandom_range(0, 1));
         cmd_words.delete();
         cmd_lats.delete();
         for (int i = 0; i < n; i++) begin
            cmd_words.push_back($urandom());
            cmd_lats.push_back(($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 5)));
         end
         run_cmd(opc, $sformatf("rnd%0d", t));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
